// File: rtl/ddr_traffic_pkg.sv
// ddr_traffic_pkg
//   Shared definitions for the DDR write-then-read traffic checker:
//   FSM state encoding, LFSR polynomial/seed constants and the
//   incrementing-pattern and LFSR-step helper functions.
package ddr_traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_DATA,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    // Galois right-shift toggle mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    // Per-pass seed is LFSR_SEED | pass_cnt
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0000;

    // Incrementing pattern: word address XOR pass number in the upper half,
    // so consecutive passes never write identical data.
    function automatic logic [31:0] pat_word(input logic [31:0] addr,
                                             input logic [7:0]  beat,
                                             input logic [15:0] pass);
        return (addr + {24'h0, beat}) ^ {pass, 16'h0};
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/ddr_traffic_pat.sv
// ddr_traffic_pat
//   Pattern generator for one direction (write or read) of the checker.
//   Produces the 32-bit pattern word for the current beat; the caller
//   replicates it across the data bus.
//   Optional feature macro: TRAFFIC_LFSR_EN -- when defined, i_sel=1 selects
//   a 32-bit Galois LFSR seeded on i_load and stepped on i_adv. When not
//   defined only the incrementing pattern exists and i_sel is ignored.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_load         reseed LFSR from i_pass (pass start)
//   i_adv          step LFSR by one beat
//   i_sel          1 = LFSR pattern, 0 = incrementing pattern
//   i_pass         current pass count
//   i_base, i_beat burst start word address and beat index
//   o_word         pattern word for the current beat
module ddr_traffic_pat
    import ddr_traffic_pkg::*;
#(
    parameter int ADDR_WIDTH = 28
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_adv,
    input  logic                  i_sel,
    input  logic [15:0]           i_pass,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [7:0]            i_beat,
    output logic [31:0]           o_word
);

    logic [31:0] w_inc;
    assign w_inc = pat_word(32'(i_base), i_beat, i_pass);

`ifdef TRAFFIC_LFSR_EN
    logic [31:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_lfsr <= '0;
        else if (i_load)
            r_lfsr <= LFSR_SEED | {16'h0, i_pass};
        else if (i_adv)
            r_lfsr <= lfsr_next(r_lfsr);
    end

    assign o_word = i_sel ? r_lfsr : w_inc;
`else
    // Sequencing inputs only matter to the LFSR variant.
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst, i_load, i_adv, i_sel};
    assign o_word   = w_inc;
`endif

endmodule

// File: rtl/ddr_traffic_chk.sv
// ddr_traffic_chk
//   Write-then-read traffic generator/checker for the controller user port.
//   Writes NUM_BURSTS bursts of BURST_LEN beats from address 0, reads them
//   back, compares each beat and reports pass/error status. Optionally loops.
//   Optional feature macro: TRAFFIC_LFSR_EN (LFSR pattern selectable by i_pat_sel).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_init_done         controller init complete; start ignored while low
//   i_start             one-cycle pass request
//   i_loop_en           sampled in DONE: 1 = run another pass
//   i_pat_sel           pattern select (LFSR build only)
//   o_busy, o_done      activity / end-of-pass pulse
//   o_pass_cnt          completed passes (wraps)
//   o_err_flag/cnt/addr sticky flag, saturating count, first failing address
//   o_cmd_*/i_cmd_ready command channel
//   o_wdata_*/i_wdata_ready write data channel
//   i_rdata_*           read data channel (no backpressure)
module ddr_traffic_chk
    import ddr_traffic_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 28,
    parameter int BURST_LEN  = 8,
    parameter int NUM_BURSTS = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_init_done,
    input  logic                  i_start,
    input  logic                  i_loop_en,
    input  logic                  i_pat_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_pass_cnt,
    output logic                  o_err_flag,
    output logic [15:0]           o_err_cnt,
    output logic [ADDR_WIDTH-1:0] o_err_addr,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic                  o_cmd_write,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [7:0]            o_cmd_len,
    output logic                  o_wdata_valid,
    input  logic                  i_wdata_ready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wdata_last,
    input  logic                  i_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_rdata_last
);

    localparam int                    REP        = DATA_WIDTH / 32;
    localparam int                    BW         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [7:0]            LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [BW-1:0]         LAST_BURST = BW'(NUM_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] BL_A       = ADDR_WIDTH'(BURST_LEN);

    state_t                r_state, w_state_nx;
    logic [BW-1:0]         r_burst;
    logic [7:0]            r_beat;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_wd_arm;
    logic [15:0]           r_pass_cnt;
    logic                  r_err_flag;
    logic [15:0]           r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_err_addr;

    logic                  w_start_ok, w_cmd_fire, w_wr_fire, w_rd_fire;
    logic                  w_beat_last, w_burst_last;
    logic [31:0]           w_wr_word, w_rd_word;
    logic                  w_mis_data, w_mis_last;
    logic [1:0]            w_err_inc;
    logic [16:0]           w_err_sum;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic                  w_pat_load;

    assign w_start_ok   = (r_state == ST_IDLE) && i_start && i_init_done;
    assign w_cmd_fire   = o_cmd_valid && i_cmd_ready;
    assign w_wr_fire    = r_wd_arm && i_wdata_ready;
    assign w_rd_fire    = (r_state == ST_RD_DATA) && i_rdata_valid;
    assign w_beat_last  = (r_beat == LAST_BEAT);
    assign w_burst_last = (r_burst == LAST_BURST);
    assign w_beat_addr  = r_base + ADDR_WIDTH'(r_beat);
    // First WR_CMD of a pass: pass_cnt is already final, so seed both generators.
    assign w_pat_load   = (r_state == ST_WR_CMD) && (r_burst == '0);

    ddr_traffic_pat #(.ADDR_WIDTH(ADDR_WIDTH)) u_pat_wr (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(w_pat_load), .i_adv(w_wr_fire),
        .i_sel(i_pat_sel), .i_pass(r_pass_cnt), .i_base(r_base), .i_beat(r_beat),
        .o_word(w_wr_word)
    );

    ddr_traffic_pat #(.ADDR_WIDTH(ADDR_WIDTH)) u_pat_rd (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(w_pat_load), .i_adv(w_rd_fire),
        .i_sel(i_pat_sel), .i_pass(r_pass_cnt), .i_base(r_base), .i_beat(r_beat),
        .o_word(w_rd_word)
    );

    // Compare is combinational on the arriving beat and lands in the error
    // registers at the same edge, so the last beat is reflected by the DONE cycle.
    assign w_mis_data = w_rd_fire && (i_rdata != {REP{w_rd_word}});
    // rdata_last is only checked, never used for sequencing: the beat
    // counter alone decides where a burst ends.
    assign w_mis_last = w_rd_fire && (i_rdata_last != w_beat_last);
    assign w_err_inc  = {1'b0, w_mis_data} + {1'b0, w_mis_last};
    assign w_err_sum  = {1'b0, r_err_cnt} + {15'h0, w_err_inc};

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_ok) w_state_nx = ST_WR_CMD;
            ST_WR_CMD:  if (w_cmd_fire) w_state_nx = ST_WR_DATA;
            ST_WR_DATA: if (w_wr_fire && w_beat_last)
                            w_state_nx = w_burst_last ? ST_RD_CMD : ST_WR_CMD;
            ST_RD_CMD:  if (w_cmd_fire) w_state_nx = ST_RD_DATA;
            ST_RD_DATA: if (w_rd_fire && w_beat_last)
                            w_state_nx = w_burst_last ? ST_DONE : ST_RD_CMD;
            ST_DONE:    w_state_nx = i_loop_en ? ST_WR_CMD : ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_burst    <= '0;
            r_beat     <= '0;
            r_base     <= '0;
            r_wd_arm   <= 1'b0;
            r_pass_cnt <= '0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
        end else begin
            r_state  <= w_state_nx;
            // Write valid starts one cycle after entering WR_DATA and drops
            // with the last beat of the burst.
            r_wd_arm <= (r_state == ST_WR_DATA) && (w_state_nx == ST_WR_DATA);

            if (w_start_ok) begin
                r_burst    <= '0;
                r_beat     <= '0;
                r_base     <= '0;
                r_err_flag <= 1'b0;
                r_err_cnt  <= '0;
                r_err_addr <= '0;
            end

            // Write and read phases share the burst/beat counters; both wrap
            // to zero after the last burst so the next phase starts at 0.
            if (w_wr_fire || w_rd_fire) begin
                if (w_beat_last) begin
                    r_beat <= '0;
                    if (w_burst_last) begin
                        r_burst <= '0;
                        r_base  <= '0;
                    end else begin
                        r_burst <= r_burst + BW'(1);
                        r_base  <= r_base + BL_A;
                    end
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end

            if (w_rd_fire && w_beat_last && w_burst_last)
                r_pass_cnt <= r_pass_cnt + 16'd1;

            if (w_err_inc != 2'd0) begin
                r_err_flag <= 1'b1;
                r_err_cnt  <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
                if (!r_err_flag)
                    r_err_addr <= w_beat_addr;
            end
        end
    end

    // busy drops in the DONE cycle itself when no further pass follows.
    assign o_busy        = (r_state != ST_IDLE) && !((r_state == ST_DONE) && !i_loop_en);
    assign o_done        = (r_state == ST_DONE);
    assign o_pass_cnt    = r_pass_cnt;
    assign o_err_flag    = r_err_flag;
    assign o_err_cnt     = r_err_cnt;
    assign o_err_addr    = r_err_addr;
    assign o_cmd_valid   = (r_state == ST_WR_CMD) || (r_state == ST_RD_CMD);
    assign o_cmd_write   = (r_state == ST_WR_CMD);
    assign o_cmd_addr    = o_cmd_valid ? r_base : '0;
    assign o_cmd_len     = o_cmd_valid ? LAST_BEAT : 8'd0;
    assign o_wdata_valid = r_wd_arm;
    assign o_wdata       = r_wd_arm ? {REP{w_wr_word}} : '0;
    assign o_wdata_last  = r_wd_arm && w_beat_last;

endmodule

// File: tb/tb_ddr_traffic_chk.sv
module tb_ddr_traffic_chk;
    localparam int DW = 64, AW = 16, BL = 4, NB = 8, SPAN = BL * NB;

    logic clk = 1'b0, rst = 1'b1, init_done = 1'b0, start = 1'b0, loop_en = 1'b0, pat_sel = 1'b0;
    logic busy, done, err_flag, cmd_valid, cmd_write, wdata_valid, wdata_last;
    logic [15:0] pass_cnt, err_cnt;
    logic [AW-1:0] err_addr, cmd_addr;
    logic [7:0] cmd_len;
    logic [DW-1:0] wdata;
    logic cmd_ready = 1'b0, wdata_ready = 1'b0, rdata_valid = 1'b0, rdata_last = 1'b0;
    logic [DW-1:0] rdata = '0;

    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    ddr_traffic_chk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
        .i_clk(clk), .i_rst(rst), .i_init_done(init_done), .i_start(start),
        .i_loop_en(loop_en), .i_pat_sel(pat_sel),
        .o_busy(busy), .o_done(done), .o_pass_cnt(pass_cnt),
        .o_err_flag(err_flag), .o_err_cnt(err_cnt), .o_err_addr(err_addr),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_write(cmd_write),
        .o_cmd_addr(cmd_addr), .o_cmd_len(cmd_len),
        .o_wdata_valid(wdata_valid), .i_wdata_ready(wdata_ready),
        .o_wdata(wdata), .o_wdata_last(wdata_last),
        .i_rdata_valid(rdata_valid), .i_rdata(rdata), .i_rdata_last(rdata_last)
    );

    // ---------------- behavioural memory (3-cycle read latency) -------------
    typedef struct { int a; bit last; int t; } rd_beat_t;
    rd_beat_t rd_q[$];
    logic [DW-1:0] mem [0:SPAN-1];
    bit flip [0:SPAN-1];
    int drop_last_burst = -1, early_last_burst = -1, rdy_pct = 100;
    int wcmd_q[$], rcmd_q[$];
    logic [DW-1:0] wr0_q[$];
    int wr_base = 0, wr_beat = 0, rd_beats = 0;
    bit stall_p = 1'b0;
    logic [DW-1:0] stall_d = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rd_q.delete();
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("wvalid_held", wdata_valid, 1'b1);
                chk("wdata_stable", wdata, stall_d);
            end
            if (cmd_valid && cmd_ready) begin
                chk("cmd_len", cmd_len, BL - 1);
                if (cmd_write) begin
                    wcmd_q.push_back(int'(cmd_addr));
                    wr_base = int'(cmd_addr);
                    wr_beat = 0;
                end else begin
                    rcmd_q.push_back(int'(cmd_addr));
                    for (int b = 0; b < BL; b++)
                        rd_q.push_back('{a: int'(cmd_addr) + b, last: (b == BL - 1), t: cyc + 3});
                end
            end
            if (wdata_valid && wdata_ready) begin
                chk("wdata_last", wdata_last, (wr_beat == BL - 1));
                if (wr_base + wr_beat < SPAN) mem[wr_base + wr_beat] = wdata;
                if (wr_base + wr_beat == 0) wr0_q.push_back(wdata);
                wr_beat++;
            end
            if (rdata_valid) rd_beats++;
            stall_p = wdata_valid && !wdata_ready;
            stall_d = wdata;
        end
    end

    always @(negedge clk) begin
        rd_beat_t e;
        if (rst) begin
            rdata_valid = 1'b0; rdata_last = 1'b0; rdata = '0;
            cmd_ready = 1'b0; wdata_ready = 1'b0;
        end else begin
            cmd_ready   = ($urandom_range(0, 99) < rdy_pct);
            wdata_ready = ($urandom_range(0, 99) < rdy_pct);
            if (rd_q.size() > 0 && rd_q[0].t <= cyc) begin
                e = rd_q.pop_front();
                rdata_valid = 1'b1;
                rdata       = mem[e.a] ^ (flip[e.a] ? 64'h20 : 64'h0);
                rdata_last  = e.last;
                if (e.a / BL == drop_last_burst && e.last) rdata_last = 1'b0;
                if (e.a / BL == early_last_burst && e.a % BL == 1) rdata_last = 1'b1;
            end else begin
                rdata_valid = 1'b0; rdata_last = 1'b0; rdata = '0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] exp_inc(input int a, input int pass);
        logic [31:0] w;
        w = 32'(a) ^ (32'(pass) << 16);
        return {w, w};
    endfunction

    task automatic clear_env();
        for (int i = 0; i < SPAN; i++) begin
            mem[i] = 64'hDEAD_BEEF_DEAD_BEEF;
            flip[i] = 1'b0;
        end
        wcmd_q.delete(); rcmd_q.delete(); wr0_q.delete();
        rd_beats = 0; drop_last_burst = -1; early_last_burst = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output bit busy_at);
        bit seen;
        seen = 1'b0; busy_at = 1'b1;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; busy_at = busy; end
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic check_mem(input string tag, input int pass);
        int bad;
        bad = 0;
        for (int i = 0; i < SPAN; i++) if (mem[i] !== exp_inc(i, pass)) bad++;
        chk(tag, bad, 0);
    endtask

    // Run one pass with faulted words a0/a1 (-1 = unused); expectations derived
    // from the set of corrupted addresses.
    task automatic run_fault(input string tag, input int a0, input int a1);
        bit b;
        int n, lo;
        clear_env();
        rdy_pct = 30;
        n = 0; lo = SPAN;
        if (a0 >= 0) begin flip[a0] = 1'b1; n++; lo = a0; end
        if (a1 >= 0) begin flip[a1] = 1'b1; n++; if (a1 < lo) lo = a1; end
        pulse_start();
        chk({tag, "_cleared"}, {err_flag, err_cnt}, 0);
        wait_done(tag, b);
        chk({tag, "_err_cnt"}, err_cnt, n);
        chk({tag, "_err_flag"}, err_flag, 1'b1);
        chk({tag, "_err_addr"}, err_addr, lo);
    endtask

    initial begin
        bit b;
        int bad, ok, r0, r1, extra;
        logic [31:0] s;

        clear_env();
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, done, cmd_valid, wdata_valid, err_flag}, 0);
        chk("rst_cnts", {pass_cnt, err_cnt}, 0);
        rst = 1'b0;

        // start ignored before init_done
        pulse_start();
        repeat (4) @(negedge clk);
        chk("guard_busy", busy, 1'b0);
        chk("guard_cmd", cmd_valid, 1'b0);
        init_done = 1'b1;

        // 1. clean pass
        clear_env(); rdy_pct = 100;
        pulse_start();
        chk("s1_busy", busy, 1'b1);
        wait_done("s1", b);
        chk("s1_busy_at_done", b, 1'b0);
        chk("s1_pass_cnt", pass_cnt, 1);
        chk("s1_errs", {err_flag, err_cnt}, 0);
        check_mem("s1_mem", 0);
        chk("s1_nwcmd", wcmd_q.size(), NB);
        chk("s1_nrcmd", rcmd_q.size(), NB);
        bad = 0;
        for (int i = 0; i < NB; i++)
            if (i >= wcmd_q.size() || i >= rcmd_q.size() || wcmd_q[i] != i * BL || rcmd_q[i] != i * BL) bad++;
        chk("s1_cmd_addr", bad, 0);
        chk("s1_rd_beats", rd_beats, SPAN);
        @(negedge clk);
        chk("s1_idle", busy, 1'b0);

        // 2. backpressure (pat_sel toggled where it has no effect)
        clear_env(); rdy_pct = 30;
`ifndef TRAFFIC_LFSR_EN
        pat_sel = 1'b1;
`endif
        pulse_start();
        wait_done("s2", b);
        pat_sel = 1'b0;
        check_mem("s2_mem", 1);
        chk("s2_errs", {err_flag, err_cnt}, 0);
        chk("s2_pass_cnt", pass_cnt, 2);

        // 3. fault injection
        run_fault("f1", 'h0A, -1);
        run_fault("f2", 'h0A, 'h13);
        r0 = $urandom_range(0, SPAN - 1);
        r1 = (r0 + 1 + $urandom_range(0, SPAN - 2)) % SPAN;
        run_fault("frnd", r0, r1);

        // rdata_last protocol errors
        clear_env(); rdy_pct = 100; drop_last_burst = 5;
        pulse_start(); wait_done("ldrop", b);
        chk("ldrop_cnt", err_cnt, 1);
        chk("ldrop_addr", err_addr, 5 * BL + BL - 1);
        clear_env(); early_last_burst = 2;
        pulse_start(); wait_done("learly", b);
        chk("learly_cnt", err_cnt, 1);
        chk("learly_addr", err_addr, 2 * BL + 1);
        chk("learly_pass", pass_cnt, 7);

        // 5. reset in the middle of the read phase
        clear_env();
        pulse_start();
        ok = 0;
        for (int i = 0; i < 2000 && ok == 0; i++) begin
            @(negedge clk);
            if (rd_beats >= 2) ok = 1;
        end
        chk("rst_reach_rd", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", {busy, done, cmd_valid, cmd_write, wdata_valid, wdata_last, err_flag}, 0);
        chk("rst_mid_bus", {cmd_addr, cmd_len, err_cnt, err_addr}, 0);
        chk("rst_mid_wdata", wdata, 0);
        chk("rst_mid_pass", pass_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // 4. loop for three passes
        clear_env(); loop_en = 1'b1;
        pulse_start();
        wait_done("lp1", b); chk("lp1_busy", b, 1'b1);
        wait_done("lp2", b); chk("lp2_busy", b, 1'b1);
        repeat (3) @(negedge clk);
        loop_en = 1'b0;
        wait_done("lp3", b); chk("lp3_busy", b, 1'b0);
        chk("lp_pass_cnt", pass_cnt, 3);
        chk("lp_errs", {err_flag, err_cnt}, 0);
        chk("lp_npasses", wr0_q.size(), 3);
        chk("lp_pass2_word", (wr0_q.size() > 1) ? wr0_q[1] : 64'h0, 64'h0001_0000_0001_0000);
        check_mem("lp_mem", 2);
        extra = 0;
        repeat (20) begin @(negedge clk); if (done || busy) extra++; end
        chk("lp_stopped", extra, 0);

`ifdef TRAFFIC_LFSR_EN
        // 6. LFSR pattern
        clear_env(); pat_sel = 1'b1;
        pulse_start();
        wait_done("lfsr", b);
        s = 32'hACE1_0000 | 32'd3;
        chk("lfsr_first", (wr0_q.size() > 0) ? wr0_q[0] : 64'h0, {s, s});
        bad = 0;
        for (int i = 0; i < SPAN; i++) begin
            if (mem[i] !== {s, s}) bad++;
            s = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
        chk("lfsr_mem", bad, 0);
        chk("lfsr_errs", {err_flag, err_cnt}, 0);
        chk("lfsr_pass", pass_cnt, 4);
        pat_sel = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
